// File: rtl/tlb_maint_ctrl_if.sv
// Command/response channel between the execute/CSR stage (master) and tlb_maint_ctrl (slave).
interface tlb_maint_ctrl_if #(
  parameter int IDXW    = 5,
  parameter int ENTRY_W = 89
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [IDXW-1:0]    cmd_index;
  logic [ENTRY_W-1:0] cmd_entry;
  logic [4:0]         cmd_inv_op;
  logic [9:0]         cmd_asid;
  logic [18:0]        cmd_vppn;
  logic               rsp_valid;
  logic               rsp_found;
  logic [IDXW-1:0]    rsp_index;
  logic [ENTRY_W-1:0] rsp_entry;
  logic               busy;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_entry, cmd_inv_op, cmd_asid, cmd_vppn,
    input  cmd_ready, rsp_valid, rsp_found, rsp_index, rsp_entry, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_entry, cmd_inv_op, cmd_asid, cmd_vppn,
    output cmd_ready, rsp_valid, rsp_found, rsp_index, rsp_entry, busy
  );
endinterface

// File: rtl/tlb_maint_ctrl.sv
// Sequences one TLB maintenance command (search/read/write/fill/invalidate) at a time into the
// TLB storage ports and returns a one-cycle response pulse; owns the fill LFSR and sweep counter.
module tlb_maint_ctrl #(
  parameter int         TLBNUM    = 32,
  parameter int         NSET      = 8,
  parameter int         ENTRY_W   = 89,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tlb_maint_ctrl_if.slave           cmd_if,
  output logic                      tlb_we,
  output logic [$clog2(TLBNUM)-1:0] tlb_w_index,
  output logic [ENTRY_W-1:0]        tlb_wdata,
  output logic [$clog2(TLBNUM)-1:0] tlb_r_index,
  input  logic [ENTRY_W-1:0]        tlb_rdata,
  output logic                      tlb_s_fetch,
  output logic [18:0]               tlb_s_vppn,
  output logic [9:0]                tlb_s_asid,
  output logic                      tlb_s_odd_page,
  input  logic                      tlb_s_found,
  input  logic [$clog2(TLBNUM)-1:0] tlb_s_index,
  output logic                      tlb_inv_en,
  output logic [4:0]                tlb_inv_op,
  output logic [9:0]                tlb_inv_asid,
  output logic [18:0]               tlb_inv_vpn
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam int CNTW = (NSET > 1) ? $clog2(NSET) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NSET - 1);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_SWAIT = 3'd2,
    ST_INV   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // x^8+x^6+x^5+x^4+1; a non-zero seed never reaches the all-zero lock-up state
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t state_r, state_nx_s;
  logic [7:0]      lfsr_r;
  logic [2:0]      op_r;
  logic [IDXW-1:0] index_r;
  logic [CNTW-1:0] cnt_r;
  logic accept_s, op_go_s, sweep_s;

  logic cmd_ready_r, busy_r, rsp_valid_r, rsp_found_r;
  logic [IDXW-1:0] rsp_index_r;
  logic [ENTRY_W-1:0] rsp_entry_r;
  logic rsp_found_nx_s;
  logic [IDXW-1:0] rsp_index_nx_s;
  logic [ENTRY_W-1:0] rsp_entry_nx_s;

  logic we_r, we_nx_s, fetch_r, fetch_nx_s, inv_en_r, inv_en_nx_s;
  logic [IDXW-1:0] w_index_r, w_index_nx_s, r_index_r, r_index_nx_s;
  logic [ENTRY_W-1:0] wdata_r, wdata_nx_s;
  logic [18:0] s_vppn_r, s_vppn_nx_s, inv_vpn_r, inv_vpn_nx_s;
  logic [9:0]  s_asid_r, s_asid_nx_s, inv_asid_r, inv_asid_nx_s;
  logic [4:0]  inv_op_r, inv_op_nx_s;

  // Next state; out-of-range ops and INVTLB ops above 6 complete without touching the TLB
  always_comb begin
    accept_s   = cmd_if.cmd_valid && (state_r == ST_IDLE);
    op_go_s    = (cmd_if.cmd_op <= OP_FILL) ||
                 ((cmd_if.cmd_op == OP_INV) && (cmd_if.cmd_inv_op <= 5'd6));
    sweep_s    = ((state_r == ST_EXEC) || (state_r == ST_INV)) && (op_r == OP_INV);
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = op_go_s ? ST_EXEC : ST_RESP;
        else          state_nx_s = ST_IDLE;
      end
      ST_EXEC: begin
        if (op_r == OP_SRCH)     state_nx_s = ST_SWAIT;
        else if (op_r == OP_INV) state_nx_s = (cnt_r == CNT_LAST) ? ST_RESP : ST_INV;
        else                     state_nx_s = ST_RESP;
      end
      ST_SWAIT: state_nx_s = ST_RESP;
      ST_INV:   state_nx_s = (cnt_r == CNT_LAST) ? ST_RESP : ST_INV;
      ST_RESP:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // TLB port strobes for the next cycle, launched from the accept edge
  always_comb begin
    we_nx_s       = 1'b0;
    w_index_nx_s  = '0;
    wdata_nx_s    = '0;
    r_index_nx_s  = '0;
    fetch_nx_s    = 1'b0;
    s_vppn_nx_s   = '0;
    s_asid_nx_s   = '0;
    inv_en_nx_s   = 1'b0;
    inv_op_nx_s   = '0;
    inv_asid_nx_s = '0;
    inv_vpn_nx_s  = '0;
    if (accept_s && op_go_s) begin
      case (cmd_if.cmd_op)
        OP_SRCH: begin
          fetch_nx_s  = 1'b1;
          s_vppn_nx_s = cmd_if.cmd_vppn;
          s_asid_nx_s = cmd_if.cmd_asid;
        end
        OP_RD: r_index_nx_s = cmd_if.cmd_index;
        OP_WR, OP_FILL: begin
          we_nx_s      = 1'b1;
          w_index_nx_s = (cmd_if.cmd_op == OP_FILL) ? lfsr_r[IDXW-1:0] : cmd_if.cmd_index;
          wdata_nx_s   = cmd_if.cmd_entry;
        end
        OP_INV: begin
          inv_en_nx_s   = 1'b1;
          inv_op_nx_s   = cmd_if.cmd_inv_op;
          inv_asid_nx_s = cmd_if.cmd_asid;
          inv_vpn_nx_s  = cmd_if.cmd_vppn;
        end
        default: inv_en_nx_s = 1'b0;
      endcase
    end else if (state_nx_s == ST_INV) begin
      inv_en_nx_s   = 1'b1;
      inv_op_nx_s   = inv_op_r;
      inv_asid_nx_s = inv_asid_r;
      inv_vpn_nx_s  = inv_vpn_r;
    end else begin
      inv_en_nx_s = 1'b0;
    end
  end

  // Response fields change only on entry to RESP and hold until the next one
  always_comb begin
    rsp_found_nx_s = rsp_found_r;
    rsp_index_nx_s = rsp_index_r;
    rsp_entry_nx_s = rsp_entry_r;
    if (state_nx_s == ST_RESP) begin
      rsp_found_nx_s = 1'b0;
      rsp_index_nx_s = '0;
      rsp_entry_nx_s = '0;
      case (state_r)
        ST_SWAIT: begin
          rsp_found_nx_s = tlb_s_found;
          rsp_index_nx_s = tlb_s_index;
        end
        ST_EXEC: begin
          rsp_index_nx_s = (op_r == OP_INV) ? '0 : index_r;
          rsp_entry_nx_s = (op_r == OP_RD) ? tlb_rdata : '0;
        end
        default: rsp_found_nx_s = 1'b0;
      endcase
    end else begin
      rsp_found_nx_s = rsp_found_r;
    end
  end

  // State, command capture, sweep counter, LFSR and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= LFSR_SEED;
      op_r        <= 3'd0;
      index_r     <= '0;
      cnt_r       <= '0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_found_r <= 1'b0;
      rsp_index_r <= '0;
      rsp_entry_r <= '0;
      we_r        <= 1'b0;
      w_index_r   <= '0;
      wdata_r     <= '0;
      r_index_r   <= '0;
      fetch_r     <= 1'b0;
      s_vppn_r    <= '0;
      s_asid_r    <= '0;
      inv_en_r    <= 1'b0;
      inv_op_r    <= '0;
      inv_asid_r  <= '0;
      inv_vpn_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      lfsr_r  <= lfsr_next(lfsr_r);
      if (accept_s) begin
        op_r    <= cmd_if.cmd_op;
        index_r <= (cmd_if.cmd_op == OP_FILL) ? lfsr_r[IDXW-1:0] : cmd_if.cmd_index;
      end
      cnt_r       <= sweep_s ? (cnt_r + CNTW'(1'b1)) : '0;
      cmd_ready_r <= (state_nx_s == ST_IDLE);
      busy_r      <= (state_nx_s != ST_IDLE);
      rsp_valid_r <= (state_nx_s == ST_RESP);
      rsp_found_r <= rsp_found_nx_s;
      rsp_index_r <= rsp_index_nx_s;
      rsp_entry_r <= rsp_entry_nx_s;
      we_r        <= we_nx_s;
      w_index_r   <= w_index_nx_s;
      wdata_r     <= wdata_nx_s;
      r_index_r   <= r_index_nx_s;
      fetch_r     <= fetch_nx_s;
      s_vppn_r    <= s_vppn_nx_s;
      s_asid_r    <= s_asid_nx_s;
      inv_en_r    <= inv_en_nx_s;
      inv_op_r    <= inv_op_nx_s;
      inv_asid_r  <= inv_asid_nx_s;
      inv_vpn_r   <= inv_vpn_nx_s;
    end
  end

  assign cmd_if.cmd_ready = cmd_ready_r;
  assign cmd_if.busy      = busy_r;
  assign cmd_if.rsp_valid = rsp_valid_r;
  assign cmd_if.rsp_found = rsp_found_r;
  assign cmd_if.rsp_index = rsp_index_r;
  assign cmd_if.rsp_entry = rsp_entry_r;
  assign tlb_we           = we_r;
  assign tlb_w_index      = w_index_r;
  assign tlb_wdata        = wdata_r;
  assign tlb_r_index      = r_index_r;
  assign tlb_s_fetch      = fetch_r;
  assign tlb_s_vppn       = s_vppn_r;
  assign tlb_s_asid       = s_asid_r;
  assign tlb_s_odd_page   = 1'b0;
  assign tlb_inv_en       = inv_en_r;
  assign tlb_inv_op       = inv_op_r;
  assign tlb_inv_asid     = inv_asid_r;
  assign tlb_inv_vpn      = inv_vpn_r;
endmodule
